// File: rtl/fanout_pipe_bcast.sv
`default_nettype none
// ============================================================================
//  Module   : fanout_pipe_bcast
//  Purpose  : Broadcasts one valid/ready input stream to NUM_CH output
//             channels. Each channel owns an independent DEPTH-entry FIFO, so
//             loads drain at their own pace. The source is only held off when
//             an enabled channel's FIFO is full.
//  Ports    : clk, rst_n               - clock, async active-low reset
//             in_valid/in_ready/in_data - source handshake and data
//             ch_en[NUM_CH]             - per-channel broadcast enable,
//                                         sampled in the accept cycle
//             out_valid/out_ready[NUM_CH]
//                                       - per-channel handshake
//             out_data[NUM_CH*WIDTH]    - channel i data in [i*WIDTH +: WIDTH]
//             stall_cnt[16]             - saturating count of cycles with
//                                         in_valid & !in_ready (optional)
//  Options  : FANOUT_STALL_CNT_EN - when defined, adds the stall_cnt port and
//             its counter. When undefined, both are removed.
//  Revision : 1.0 - initial release
// ============================================================================
module fanout_pipe_bcast #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data
`ifdef FANOUT_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_block;
    logic              w_accept;

    // in_ready depends only on registered counts and ch_en, never on
    // out_ready, so there is no combinational path from the loads back to
    // the source.
    assign in_ready = ~|w_block;
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [C_CNT_W-1:0] count_q,  count_d;
            logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [WIDTH-1:0]   mem_q [DEPTH];
            logic [WIDTH-1:0]   mem_d [DEPTH];
            logic               w_push;
            logic               w_pop;

            assign w_full[i]  = (count_q == C_FULL);
            assign w_block[i] = ch_en[i] & w_full[i];

            // An enabled channel can never be full when a push happens,
            // because the full state already dropped in_ready.
            assign w_push = w_accept & ch_en[i];
            assign w_pop  = (count_q != '0) & out_ready[i];

            always_comb begin
                count_d  = count_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                mem_d    = mem_q;
                if (w_push) begin
                    mem_d[wr_ptr_q] = in_data;
                    // Pointer width is log2(DEPTH), so the increment wraps
                    // modulo DEPTH by itself.
                    wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
                end
                if (w_pop) begin
                    rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   count_d = count_q + C_CNT_W'(1);
                    2'b01:   count_d = count_q - C_CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q  <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        mem_q[j] <= '0;
                    end
                end else begin
                    count_q  <= count_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    mem_q    <= mem_d;
                end
            end

            assign out_valid[i]                  = (count_q != '0);
            assign out_data[i*WIDTH +: WIDTH]    = mem_q[rd_ptr_q];
        end
    endgenerate

`ifdef FANOUT_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fanout_pipe_bcast.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fanout_pipe_bcast
//  Purpose  : Directed self-checking bench for fanout_pipe_bcast with default
//             parameters (WIDTH=8, NUM_CH=4, DEPTH=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fanout_pipe_bcast;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
`ifdef FANOUT_STALL_CNT_EN
    logic [15:0]             stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fanout_pipe_bcast #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FANOUT_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        ch_en     = '0;
        out_ready = '0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 4'h0) begin
            errors++;
            $display("FAIL reset_out_valid: got %h expected %h", out_valid, 4'h0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected %b", in_ready, 1'b1);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected %h", out_data, 32'h0);
        end
    endtask

    task automatic test_broadcast();
        apply_reset();
        ch_en     = 4'hF;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'hF) begin
            errors++;
            $display("FAIL bcast_valid: got %h expected %h", out_valid, 4'hF);
        end
        checks++;
        if (out_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bcast_data: got %h expected %h", out_data, 32'hA5A5A5A5);
        end
        step();
        checks++;
        if (out_valid !== 4'h0) begin
            errors++;
            $display("FAIL bcast_drained: got %h expected %h", out_valid, 4'h0);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        ch_en     = 4'hF;
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        step();
        checks++;
        if (out_data[2*WIDTH +: WIDTH] !== 8'h01) begin
            errors++;
            $display("FAIL bp_ch2_first: got %h expected %h", out_data[2*WIDTH +: WIDTH], 8'h01);
        end
        in_data = 8'h02;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready_low: got %b expected %b", in_ready, 1'b0);
        end
        // ch2 stalled: head must still be 01.
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[2*WIDTH +: WIDTH] !== 8'h01) begin
            errors++;
            $display("FAIL bp_ch2_hold: got v=%b d=%h expected v=1 d=01",
                     out_valid[2], out_data[2*WIDTH +: WIDTH]);
        end
        checks++;
        if (out_data[0 +: WIDTH] !== 8'h02) begin
            errors++;
            $display("FAIL bp_ch0_second: got %h expected %h", out_data[0 +: WIDTH], 8'h02);
        end
        out_ready = 4'hF;
        step();
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[2*WIDTH +: WIDTH] !== 8'h02) begin
            errors++;
            $display("FAIL bp_ch2_second: got v=%b d=%h expected v=1 d=02",
                     out_valid[2], out_data[2*WIDTH +: WIDTH]);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready_back: got %b expected %b", in_ready, 1'b1);
        end
        step();
        checks++;
        if (out_valid !== 4'h0) begin
            errors++;
            $display("FAIL bp_drained: got %h expected %h", out_valid, 4'h0);
        end
    endtask

    task automatic test_partial_enable();
        apply_reset();
        ch_en     = 4'b0101;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        step();
        in_valid = 1'b0;
        ch_en    = 4'hF;   // later change must not matter
        checks++;
        if (out_valid !== 4'b0101) begin
            errors++;
            $display("FAIL partial_valid: got %b expected %b", out_valid, 4'b0101);
        end
        checks++;
        if (out_data[0 +: WIDTH] !== 8'h3C || out_data[2*WIDTH +: WIDTH] !== 8'h3C) begin
            errors++;
            $display("FAIL partial_data: got %h expected ch0/ch2=3c", out_data);
        end
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL partial_drained: got %b expected %b", out_valid, 4'b0000);
        end
    endtask

    task automatic test_all_disabled();
        apply_reset();
        ch_en     = 4'h0;
        out_ready = 4'h0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'(8'h50 + k);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL disabled_in_ready cyc%0d: got %b expected 1", k, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 4'h0) begin
                errors++;
                $display("FAIL disabled_out_valid cyc%0d: got %h expected 0", k, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_drain();
        int exp_val [NUM_CH];
        int sent;
        int cyc;
        bit done;
        apply_reset();
        for (int i = 0; i < NUM_CH; i++) exp_val[i] = 0;
        sent  = 0;
        cyc   = 0;
        done  = 1'b0;
        ch_en = 4'hF;
        while (!done && cyc < 400) begin
            in_valid  = (sent < 10);
            in_data   = 8'(sent);
            out_ready = 4'($urandom_range(0, 15));
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    checks++;
                    if (out_data[i*WIDTH +: WIDTH] !== 8'(exp_val[i])) begin
                        errors++;
                        $display("FAIL rand_ch%0d_order: got %h expected %h",
                                 i, out_data[i*WIDTH +: WIDTH], 8'(exp_val[i]));
                    end
                    exp_val[i]++;
                end
            end
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
            done = (sent == 10);
            for (int i = 0; i < NUM_CH; i++) if (exp_val[i] != 10) done = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rand_timeout: got sent=%0d ch0=%0d ch1=%0d ch2=%0d ch3=%0d expected all 10",
                     sent, exp_val[0], exp_val[1], exp_val[2], exp_val[3]);
        end
        checks++;
        if (out_valid !== 4'h0) begin
            errors++;
            $display("FAIL rand_no_extra: got %h expected %h", out_valid, 4'h0);
        end
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        ch_en     = 4'hF;
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'h0) begin
            errors++;
            $display("FAIL midrst_async: got %h expected %h", out_valid, 4'h0);
        end
        step();
        rst_n     = 1'b1;
        out_ready = 4'hF;
        step();
        step();
        checks++;
        if (out_valid !== 4'h0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL midrst_after: got v=%h d=%h expected v=0 d=0", out_valid, out_data);
        end
    endtask

`ifdef FANOUT_STALL_CNT_EN
    task automatic test_stall_cnt();
        apply_reset();
        ch_en     = 4'hF;
        out_ready = 4'h0;
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 8'(k);
            step();
        end
        checks++;
        if (stall_cnt !== 16'd18) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, 18);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd0 || out_valid !== 4'h0) begin
            errors++;
            $display("FAIL stall_rst: got cnt=%0d v=%h expected cnt=0 v=0", stall_cnt, out_valid);
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_broadcast();
        test_backpressure();
        test_partial_enable();
        test_all_disabled();
        test_random_drain();
        test_reset_mid_transfer();
`ifdef FANOUT_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fanout_pipe_bcast.md
FANOUT_PIPE_BCAST -- requirements
Module: fanout_pipe_bcast

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter NUM_CH, default 4, number of output channels / load branches (>=1).
REQ-003 SHALL have parameter DEPTH, default 2, per-channel buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  source has data.
REQ-007 SHALL have port in_ready  output  1  block accepts data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  source data.
REQ-009 SHALL have port ch_en  input  NUM_CH  per-channel broadcast enable, bit i = channel i.
REQ-010 SHALL have port out_valid  output  NUM_CH  channel i head entry valid.
REQ-011 SHALL have port out_ready  input  NUM_CH  channel i load accepts.
REQ-012 SHALL have port out_data  output  NUM_CH*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port stall_cnt  output  16  stall counter, present only when FANOUT_STALL_CNT_EN is defined.

Function
REQ-014 SHALL give each channel an independent FIFO of DEPTH entries with a count of clog2(DEPTH+1) bits.
REQ-015 SHALL drive in_ready = AND over i of (!ch_en[i] | !full[i]); full derived from registered count only.
REQ-016 SHALL have no combinational path from out_ready to in_ready or out_valid.
REQ-017 SHALL accept a transfer when in_valid & in_ready, writing in_data into every channel whose ch_en bit is 1 in that cycle.
REQ-018 SHALL sample ch_en only in the accept cycle; later changes do not affect entries already written.
REQ-019 SHALL, for a disabled channel, write nothing but continue draining its existing entries.
REQ-020 SHALL, with ch_en all zero, hold in_ready = 1 and discard accepted data.
REQ-021 SHALL drive out_valid[i] = (count[i] != 0) and out_data slice i = head entry of FIFO i.
REQ-022 SHALL pop channel i when out_valid[i] & out_ready[i].
REQ-023 SHALL provide latency of exactly 1 cycle: data accepted in cycle N is visible on out_valid/out_data in cycle N+1 when the FIFO was empty.
REQ-024 SHALL, on simultaneous push and pop on one channel, keep count unchanged and preserve FIFO order.
REQ-025 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-026 SHALL let channels drain independently; a stalled channel blocks new input only via REQ-015.
REQ-027 SHALL hold out_data stable while out_valid[i] & !out_ready[i].

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear all counts and pointers, giving out_valid = 0 and in_ready = 1.
REQ-029 SHALL clear all storage to zero so that out_data = 0 after reset.
REQ-030 SHALL clear stall_cnt to 0 when present.
REQ-031 SHALL, on reset asserted mid-transfer, discard all buffered entries; no data appears after release until a new accept.
REQ-032 SHALL deassert reset synchronously to clk externally; the block performs no internal reset synchronisation.

Configuration
REQ-033 SHALL, with FANOUT_STALL_CNT_EN defined, increment stall_cnt by 1 every cycle where in_valid & !in_ready, saturating at 16'hFFFF.
REQ-034 SHALL, without FANOUT_STALL_CNT_EN, omit the stall_cnt port and its logic entirely, with all other behaviour identical.

Verification
REQ-035 SHALL cover: reset, ch_en=4'hF, push 8'hA5, all out_ready=1 -> cycle+1 out_valid=4'hF, all slices 8'hA5; cycle+2 out_valid=0.
REQ-036 SHALL cover: DEPTH=2, out_ready[2]=0, push 8'h01 then 8'h02 -> in_ready=0 next cycle; raise out_ready[2] -> ch2 yields 01 then 02, in_ready returns to 1.
REQ-037 SHALL cover: ch_en=4'b0101, push 8'h3C -> only ch0/ch2 valid with 8'h3C; ch1/ch3 out_valid stay 0.
REQ-038 SHALL cover: ch_en=0, in_valid=1 for 5 cycles -> in_ready=1 throughout, out_valid=0 throughout.
REQ-039 SHALL cover: push 10 sequential values 0..9 with random out_ready per channel -> each channel emits 0..9 in order, with no loss across pointer wrap.
REQ-040 SHALL cover: FANOUT_STALL_CNT_EN defined, channel blocked, in_valid=1 for 20 cycles -> stall_cnt=18 with DEPTH=2; rst_n pulse low mid-stall -> stall_cnt=0, out_valid=0.
